// File: rtl/read_cache_pkg.sv
// Shared widths, FSM state type and line-word select for the read cache.
package read_cache_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned LINE_W = 128;
   localparam int unsigned OFFS_W = 2;

   typedef enum logic [0:0] {
      StIdle,
      StFill
   } state_e;

   // Word k of a line sits at bits [32k+31:32k].
   function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFFS_W-1:0] offs);
      return line[offs*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/read_cache_if.sv
// CPU request/response and memory line-read signals of the read cache.
// With RCACHE_SNOOP_EN defined, the snooped memory write port is added.
interface read_cache_if;
   import read_cache_pkg::*;

   logic              req;
   logic [ADDR_W-1:0] req_addr;
   logic              ready;
   logic              resp_valid;
   logic [WORD_W-1:0] resp_data;
   logic              flush;
   logic              mem_le;
   logic [ADDR_W-1:0] mem_raddr;
   logic [LINE_W-1:0] mem_rdata;
`ifdef RCACHE_SNOOP_EN
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;

   modport slave (
      input  req, req_addr, flush, mem_rdata, mem_we, mem_waddr,
      output ready, resp_valid, resp_data, mem_le, mem_raddr
   );

   modport master (
      output req, req_addr, flush, mem_rdata, mem_we, mem_waddr,
      input  ready, resp_valid, resp_data, mem_le, mem_raddr
   );
`else
   modport slave (
      input  req, req_addr, flush, mem_rdata,
      output ready, resp_valid, resp_data, mem_le, mem_raddr
   );

   modport master (
      output req, req_addr, flush, mem_rdata,
      input  ready, resp_valid, resp_data, mem_le, mem_raddr
   );
`endif

endinterface

// File: rtl/read_cache_array.sv
// Valid/tag/data storage: one combinational read port, one write port,
// tag-qualified invalidate-by-index and clear-all.
module read_cache_array
   import read_cache_pkg::*;
#(
   parameter int unsigned LINES = 16,
   parameter int unsigned IDX_W = $clog2(LINES),
   parameter int unsigned TAG_W = ADDR_W - OFFS_W - IDX_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic              rd_valid_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [LINE_W-1:0] rd_data_o,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [TAG_W-1:0]  wr_tag_i,
   input  logic [LINE_W-1:0] wr_data_i,
   input  logic              inv_en_i,
   input  logic [IDX_W-1:0]  inv_idx_i,
   input  logic [TAG_W-1:0]  inv_tag_i,
   input  logic              clr_i
);

   logic [LINES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINE_W-1:0] data_q [LINES];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

   // Valid next-state: clear-all, then invalidate, then install (install wins).
   always_comb begin
      valid_d = valid_q;
      if (clr_i) begin
         valid_d = '0;
      end
      if (inv_en_i && valid_q[inv_idx_i] && (tag_q[inv_idx_i] == inv_tag_i)) begin
         valid_d[inv_idx_i] = 1'b0;
      end
      if (wr_en_i) begin
         valid_d[wr_idx_i] = 1'b1;
      end
   end

   // Valid bits are the only reset state; tag/data are gated by valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data storage written on install.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

endmodule

// File: rtl/read_cache.sv
// Direct-mapped read-only line cache: FSM, fill counter, address split,
// snoop compare and response register. Optional store snooping is enabled
// by defining RCACHE_SNOOP_EN.
module read_cache
   import read_cache_pkg::*;
#(
   parameter int unsigned LINES    = 16,
   parameter int unsigned FILL_LAT = 2
) (
   input logic         clk_i,
   input logic         rst_i,
   read_cache_if.slave bus_io
);

   localparam int unsigned IDX_W    = $clog2(LINES);
   localparam int unsigned TAG_W    = ADDR_W - OFFS_W - IDX_W;
   localparam int unsigned LADDR_W  = ADDR_W - OFFS_W;
   localparam logic [7:0]  LAST_CNT = 8'(FILL_LAT - 1);

   state_e              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                mem_le_q, mem_le_d;
   logic [ADDR_W-1:0]   mem_raddr_q, mem_raddr_d;
   logic [OFFS_W-1:0]   offs_q, offs_d;
   logic                resp_valid_q, resp_valid_d;
   logic [WORD_W-1:0]   resp_data_q, resp_data_d;
   logic                ready;

   logic [OFFS_W-1:0]   req_offs;
   logic [IDX_W-1:0]    req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic                rd_valid;
   logic [TAG_W-1:0]    rd_tag;
   logic [LINE_W-1:0]   rd_data;
   logic                hit;
   logic                wr_en;

   logic                snoop_we;
   logic [LADDR_W-1:0]  snoop_line;
   logic                snoop_req;
   logic                snoop_fill;

   assign req_offs = bus_io.req_addr[OFFS_W-1:0];
   assign req_idx  = bus_io.req_addr[OFFS_W +: IDX_W];
   assign req_tag  = bus_io.req_addr[ADDR_W-1 -: TAG_W];

`ifdef RCACHE_SNOOP_EN
   assign snoop_we   = bus_io.mem_we;
   assign snoop_line = bus_io.mem_waddr[ADDR_W-1:OFFS_W];
`else
   assign snoop_we   = 1'b0;
   assign snoop_line = '0;
`endif

   // A store to the looked-up line forces a miss; a store to the line in
   // flight restarts the fill so pre-store data is never installed.
   assign snoop_req  = snoop_we && (snoop_line == bus_io.req_addr[ADDR_W-1:OFFS_W]);
   assign snoop_fill = snoop_we && (snoop_line == mem_raddr_q[ADDR_W-1:OFFS_W]);
   assign hit        = rd_valid && (rd_tag == req_tag) && !snoop_req;

   read_cache_array #(
      .LINES (LINES),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_array (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rd_idx_i   (req_idx),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_en_i    (wr_en),
      .wr_idx_i   (mem_raddr_q[OFFS_W +: IDX_W]),
      .wr_tag_i   (mem_raddr_q[ADDR_W-1 -: TAG_W]),
      .wr_data_i  (bus_io.mem_rdata),
      .inv_en_i   (snoop_we),
      .inv_idx_i  (snoop_line[IDX_W-1:0]),
      .inv_tag_i  (snoop_line[LADDR_W-1 -: TAG_W]),
      .clr_i      (bus_io.flush)
   );

   // Next-state, lookup/accept and fill completion.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mem_le_d     = mem_le_q;
      mem_raddr_d  = mem_raddr_q;
      offs_d       = offs_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      wr_en        = 1'b0;
      ready        = 1'b0;
      unique case (state_q)
         StIdle: begin
            ready = !bus_io.flush;
            if (bus_io.req && ready) begin
               if (hit) begin
                  resp_valid_d = 1'b1;
                  resp_data_d  = line_word(rd_data, req_offs);
               end else begin
                  state_d     = StFill;
                  mem_le_d    = 1'b1;
                  mem_raddr_d = {bus_io.req_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
                  offs_d      = req_offs;
                  cnt_d       = '0;
               end
            end
         end
         StFill: begin
            if (snoop_fill) begin
               cnt_d = '0;
            end else if (cnt_q == LAST_CNT) begin
               wr_en        = 1'b1;
               resp_valid_d = 1'b1;
               resp_data_d  = line_word(bus_io.mem_rdata, offs_q);
               mem_le_d     = 1'b0;
               cnt_d        = '0;
               state_d      = StIdle;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
      endcase
   end

   // State, fill address and response registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         mem_le_q     <= 1'b0;
         mem_raddr_q  <= '0;
         offs_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mem_le_q     <= mem_le_d;
         mem_raddr_q  <= mem_raddr_d;
         offs_q       <= offs_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign bus_io.ready      = ready;
   assign bus_io.resp_valid = resp_valid_q;
   assign bus_io.resp_data  = resp_data_q;
   assign bus_io.mem_le     = mem_le_q;
   assign bus_io.mem_raddr  = mem_raddr_q;

endmodule

// File: doc/read_cache.md
# read_cache

Direct-mapped, read-only line cache between the CPU load/fetch path and the word-addressed main memory. Serves 32-bit reads from 128-bit (4-word) lines and refills a missing line with one line read on the memory's read port. Optionally snoops the memory write port so that lines made stale by stores are invalidated.

## Interface

Parameters:
- LINES, 16, number of cache lines; power of two, 2..1024.
- FILL_LAT, 2, cycles the line address is held on the memory read port before data is captured; 1..255.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  1  CPU read request.
- req_addr  in  16  word address.
- ready  out  1  request accepted at the edge where req && ready.
- resp_valid  out  1  one-cycle pulse; resp_data is valid.
- resp_data  out  32  read word.
- flush  in  1  invalidate all lines.
- mem_le  out  1  line-read enable to memory.
- mem_raddr  out  16  line base address; low 2 bits always 0.
- mem_rdata  in  128  line data; word k is bits [32k+31:32k].
- mem_we  in  1  snooped memory write enable (snoop build only).
- mem_waddr  in  16  snooped memory write address (snoop build only).

## Operation

- Address split:
  - offset = req_addr[1:0]
  - index = req_addr[2+IDX_W-1:2], where IDX_W = log2(LINES)
  - tag = the remaining upper bits (TAG_W = 14 - IDX_W)
- Per-line storage: valid bit, tag, 128-bit data.
- FSM states: IDLE and FILL.
- IDLE:
  - ready = !flush.
  - On accept, look up the index.
  - Hit (valid && tag match): register the selected word into resp_data and pulse resp_valid next cycle; stay in IDLE.
  - Miss: latch the address, load mem_raddr = {addr[15:2], 2'b00}, set mem_le, clear the counter, go to FILL.
- FILL:
  - ready = 0; mem_le = 1; mem_raddr held.
  - The counter increments each cycle.
  - On the cycle the counter reaches FILL_LAT-1: write mem_rdata, tag and valid=1 into the line; register word[offset] of mem_rdata into resp_data; pulse resp_valid; clear mem_le; return to IDLE.
- flush:
  - Clears every valid bit at the edge.
  - Has priority over request acceptance.
  - A fill in progress still completes and installs its line.
- Replacement: an install always overwrites the indexed line.
- resp_data holds its last value when resp_valid is low.
- rst, applied in any state (including mid-fill), takes effect at the next edge:
  - state = IDLE; all valid bits = 0; counter = 0.
  - resp_valid = 0; resp_data = 0; mem_le = 0; mem_raddr = 0.
  - ready is 1 in the first cycle after reset.
  - A cancelled fill produces no response.

## Timing

- Accept edge = T.
- Hit: resp_valid high in cycle T+1.
- Miss:
  - mem_le is high for exactly FILL_LAT cycles, T+1..T+FILL_LAT.
  - resp_valid is high in cycle T+FILL_LAT+1.
  - Miss latency = FILL_LAT+1 cycles.
- Back-to-back: ready is high in the same cycle as resp_valid, so a new request may be accepted while a response is presented.
- mem_rdata is sampled only on the last FILL cycle; memory is combinational from mem_raddr.

## Configuration

- Macro RCACHE_SNOOP_EN.
- Defined:
  - mem_we/mem_waddr exist.
  - At each edge with mem_we = 1, a valid line whose index and tag match mem_waddr is invalidated.
  - Snoop and lookup in the same cycle on the same line: the lookup sees the line invalid (forced miss).
  - Snoop hitting the line being filled: the counter restarts at 0 and the fill extends by FILL_LAT cycles from that edge. This prevents installing pre-store data.
- Not defined:
  - The ports are absent.
  - Coherence with stores is software's job, using flush.

## Structure

- Package read_cache_pkg holds:
  - ADDR_W = 16, WORD_W = 32, LINE_W = 128, OFFS_W = 2
  - the state enum {IDLE, FILL}
- Sub-module read_cache_array: valid/tag/data storage with one combinational read port and one write port. It also provides invalidate-by-index and clear-all.
- read_cache contains the FSM, counter, address split, snoop compare and response register.

## Test plan

- Reset, then read 0x0010 with memory M[0x10..0x13] = 1,2,3,4 and FILL_LAT = 2:
  - mem_le high 2 cycles with mem_raddr = 0x0010.
  - resp_data = 1 at T+3.
  - Read 0x0013 then hits: resp_data = 4 at T+1, mem_le stays 0.
- Conflict: with LINES = 16, read 0x0010 then 0x0050 (same index, different tag), then 0x0010 again:
  - Three misses, each with 2 mem_le cycles.
  - Data matches memory each time.
- flush asserted with req in the same cycle:
  - ready = 0, no accept.
  - The next read of a previously cached line misses.
- rst asserted on the second FILL cycle:
  - No resp_valid.
  - mem_le = 0 next cycle.
  - The line is not valid; a re-read misses.
- RCACHE_SNOOP_EN:
  - Cached 0x0010 plus mem_we at 0x0011 → the next read of 0x0011 misses and returns the new value.
  - mem_we to 0x0012 during the FILL of 0x0010 → the fill restarts, miss latency 4 cycles, resp_data = the new M[0x10].
